// File: rtl/mult_dadda_pipe_if.sv
// mult_dadda_pipe_if: operand and result valid/ready streams of mult_dadda_pipe.
interface mult_dadda_pipe_if #(
    parameter int WA    = 16,
    parameter int WB    = 16,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WA-1:0]        in_a;
    logic [WB-1:0]        in_b;
    logic                 in_a_signed;
    logic                 in_b_signed;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WA+WB-1:0]     out_product;
    logic [TAG_W-1:0]     out_tag;
    modport master (
        output in_valid, in_a, in_b, in_a_signed, in_b_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_product, out_tag
    );
    modport slave (
        input  in_valid, in_a, in_b, in_a_signed, in_b_signed, in_tag, out_ready,
        output in_ready, out_valid, out_product, out_tag
    );
endinterface

// File: rtl/mult_dadda_pipe.sv
// mult_dadda_pipe: pipelined signed/unsigned multiplier; a 3:2 carry-save tree spread over STAGES registers.
module mult_dadda_pipe #(
    parameter int WA     = 16,
    parameter int WB     = 16,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input logic clk,
    input logic rst_n,
    mult_dadda_pipe_if.slave bus
);
    localparam int P  = WA + WB;
    localparam int NR = WB + 2;
    function automatic int tree_levels(int n);
        int k = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            k++;
        end
        return k;
    endfunction
    localparam int LPS = (tree_levels(NR) + STAGES - 1) / STAGES;
    typedef logic [NR-1:0][P-1:0] rows_t;
    // One compression level: live rows stay packed at the low indices, the rest are constant zero.
    function automatic rows_t csa(rows_t x);
        rows_t y = '0;
        for (int i = 0; i + 2 < NR; i += 3) begin
            y[2*(i/3)]   = x[i] ^ x[i+1] ^ x[i+2];
            y[2*(i/3)+1] = ((x[i] & x[i+1]) | (x[i] & x[i+2]) | (x[i+1] & x[i+2])) << 1;
        end
        for (int i = NR - NR % 3; i < NR; i++) y[2*(NR/3) + i - (NR - NR % 3)] = x[i];
        return y;
    endfunction
    function automatic rows_t reduce(rows_t x);
        rows_t y = x;
        for (int l = 0; l < LPS; l++) y = csa(y);
        return y;
    endfunction
    function automatic logic [P-1:0] total(rows_t x);
        logic [P-1:0] s = '0;
        for (int i = 0; i < NR; i++) s += x[i];
        return s;
    endfunction
    logic [P-1:0]     a_x;
    logic [WB:0]      b_x;
    rows_t            pp;
    rows_t            last_in;
    logic [P-1:0]     prod;
    logic [STAGES-1:0] vr;
    logic [TAG_W-1:0] tr [STAGES];
    logic             adv;
    // The top bit of the extended B carries negative weight: its row is ~(A<<WB) plus a +1 row.
    always_comb begin
        a_x = {{WB{bus.in_a_signed & bus.in_a[WA-1]}}, bus.in_a};
        b_x = {bus.in_b_signed & bus.in_b[WB-1], bus.in_b};
        pp = '0;
        for (int j = 0; j < WB; j++) pp[j] = {P{b_x[j]}} & (a_x << j);
        pp[WB]   = {P{b_x[WB]}} & ~(a_x << WB);
        pp[WB+1] = P'(b_x[WB]);
    end
    assign adv             = bus.out_ready || !bus.out_valid;
    assign bus.in_ready    = adv;
    assign bus.out_valid   = vr[STAGES-1];
    assign bus.out_tag     = tr[STAGES-1];
    assign bus.out_product = prod;
    if (STAGES > 1) begin : g_mid
        rows_t dr [STAGES-1];
        always_ff @(posedge clk)
            if (adv) begin
                dr[0] <= reduce(pp);
                for (int i = 1; i < STAGES - 1; i++) dr[i] <= reduce(dr[i-1]);
            end
        assign last_in = dr[STAGES-2];
    end else begin : g_one
        assign last_in = pp;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vr   <= '0;
            prod <= '0;
            for (int i = 0; i < STAGES; i++) tr[i] <= '0;
        end else if (adv) begin
            vr    <= (vr << 1) | STAGES'(bus.in_valid);
            tr[0] <= bus.in_tag;
            for (int i = 1; i < STAGES; i++) tr[i] <= tr[i-1];
            prod  <= total(reduce(last_in));
        end
endmodule

// File: tb/tb_mult_dadda_pipe.sv
// tb_mult_dadda_pipe: directed and random checks of mult_dadda_pipe against an arithmetic scoreboard.
module tb_mult_dadda_pipe;
    logic        clk = 0;
    logic        rst_n;
    logic [1:0]  sel;
    logic        in_valid, out_ready, sa, sb;
    logic [31:0] in_a, in_b;
    logic [15:0] in_tag;
    logic        o_valid, o_ready;
    logic [31:0] o_product;
    logic [15:0] o_tag;
    int cyc = 0;
    int checks = 0, failures = 0;
    int cur_wa, cur_wb, cur_st, cur_tw, got;
    logic [31:0] amask, bmask;
    logic [15:0] tmask;
    logic [63:0] last_prod;
    bit acc, chk_lat;
    typedef struct { logic [63:0] p; logic [15:0] t; int c; } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_dadda_pipe_if #(.WA(16), .WB(16), .TAG_W(4)) i0();
    mult_dadda_pipe_if #(.WA(8), .WB(12), .TAG_W(1))  i1();
    mult_dadda_pipe_if #(.WA(8), .WB(12), .TAG_W(1))  i6();
    mult_dadda_pipe #(.WA(16), .WB(16), .STAGES(3), .TAG_W(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    mult_dadda_pipe #(.WA(8), .WB(12), .STAGES(1), .TAG_W(1))  u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    mult_dadda_pipe #(.WA(8), .WB(12), .STAGES(6), .TAG_W(1))  u6 (.clk(clk), .rst_n(rst_n), .bus(i6));

    assign i0.in_valid = in_valid && sel == 0;
    assign i1.in_valid = in_valid && sel == 1;
    assign i6.in_valid = in_valid && sel == 2;
    assign i0.in_a = in_a[15:0];
    assign i1.in_a = in_a[7:0];
    assign i6.in_a = in_a[7:0];
    assign i0.in_b = in_b[15:0];
    assign i1.in_b = in_b[11:0];
    assign i6.in_b = in_b[11:0];
    assign i0.in_tag = in_tag[3:0];
    assign i1.in_tag = in_tag[0:0];
    assign i6.in_tag = in_tag[0:0];
    assign {i0.in_a_signed, i1.in_a_signed, i6.in_a_signed} = {3{sa}};
    assign {i0.in_b_signed, i1.in_b_signed, i6.in_b_signed} = {3{sb}};
    assign {i0.out_ready, i1.out_ready, i6.out_ready} = {3{out_ready}};
    assign o_valid   = sel == 0 ? i0.out_valid : sel == 1 ? i1.out_valid : i6.out_valid;
    assign o_ready   = sel == 0 ? i0.in_ready : sel == 1 ? i1.in_ready : i6.in_ready;
    assign o_product = sel == 0 ? i0.out_product : sel == 1 ? 32'(i1.out_product) : 32'(i6.out_product);
    assign o_tag     = sel == 0 ? 16'(i0.out_tag) : sel == 1 ? 16'(i1.out_tag) : 16'(i6.out_tag);

    function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, bit xa, bit xb, int wa, int wb);
        longint va, vb;
        va = (xa && a[wa-1]) ? longint'(a) - (longint'(1) << wa) : longint'(a);
        vb = (xb && b[wb-1]) ? longint'(b) - (longint'(1) << wb) : longint'(b);
        return 64'(va * vb) & ((64'd1 << (wa + wb)) - 64'd1);
    endfunction

    task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_cfg(int s);
        sel    = 2'(s);
        cur_wa = s == 0 ? 16 : 8;
        cur_wb = s == 0 ? 16 : 12;
        cur_st = s == 0 ? 3 : (s == 1 ? 1 : 6);
        cur_tw = s == 0 ? 4 : 1;
        amask  = 32'((64'd1 << cur_wa) - 64'd1);
        bmask  = 32'((64'd1 << cur_wb) - 64'd1);
        tmask  = 16'((32'd1 << cur_tw) - 32'd1);
    endtask

    task automatic new_rand();
        in_a   = $urandom & amask;
        in_b   = $urandom & bmask;
        sa     = 1'($urandom);
        sb     = 1'($urandom);
        in_tag = 16'($urandom) & tmask;
    endtask

    // Observe just after the negedge, predict the coming posedge, then advance one cycle.
    task automatic tick();
        #1;
        chk("in_ready_rule", 64'(o_ready), 64'(out_ready || !o_valid));
        if (q.size() == 0) chk("idle_valid", 64'(o_valid), 64'd0);
        else if (o_valid) begin
            chk("product", 64'(o_product), q[0].p);
            chk("tag", 64'(o_tag), 64'(q[0].t));
            if (out_ready) begin
                if (chk_lat) chk("latency", 64'(cyc - q[0].c), 64'(cur_st));
                last_prod = 64'(o_product);
                void'(q.pop_front());
                got++;
            end
        end
        acc = in_valid && o_ready;
        if (acc) q.push_back('{ref_mul(in_a, in_b, sa, sb, cur_wa, cur_wb), in_tag & tmask, cyc});
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && q.size() > 0; n++) tick();
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic single(logic [31:0] a, logic [31:0] b, bit xa, bit xb, logic [15:0] tg, logic [63:0] exp);
        in_a = a; in_b = b; sa = xa; sb = xb; in_tag = tg; in_valid = 1;
        tick();
        in_valid = 0;
        drain();
        chk("directed", last_prod, exp);
    endtask

    initial begin
        rst_n = 1; in_valid = 0; out_ready = 1; sa = 0; sb = 0;
        in_a = 0; in_b = 0; in_tag = 0; last_prod = 0; got = 0; chk_lat = 1;
        set_cfg(0);
        #2 rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("rst_valid", 64'(o_valid), 64'd0);
            chk("rst_product", 64'(o_product), 64'd0);
            chk("rst_tag", 64'(o_tag), 64'd0);
            chk("rst_in_ready", 64'(o_ready), 64'd1);
        end
        @(negedge clk);
        rst_n = 1;
        set_cfg(0);
        single(32'hFFFF, 32'hFFFF, 0, 0, 16'd5, 64'hFFFE0001);
        single(32'h8000, 32'h8000, 1, 1, 16'd1, 64'h40000000);
        single(32'hFFFF, 32'hFFFF, 1, 1, 16'd2, 64'h00000001);
        single(32'h8000, 32'h0001, 1, 1, 16'd3, 64'hFFFF8000);
        single(32'hFFFF, 32'hFFFF, 1, 0, 16'd4, 64'hFFFF0001);
        single(32'hFFFF, 32'hFFFF, 0, 1, 16'd6, 64'hFFFF0001);
        // Back-to-back stream with a 4-cycle consumer stall in the middle.
        chk_lat = 0; got = 0;
        new_rand();
        in_valid = 1;
        for (int k = 0, sent = 0; k < 200 && (sent < 20 || q.size() > 0); k++) begin
            out_ready = !(k >= 6 && k < 10);
            tick();
            if (acc) begin
                sent++;
                if (sent < 20) new_rand();
                else in_valid = 0;
            end
        end
        chk("stream_count", 64'(got), 64'd20);
        out_ready = 1;
        // Reset with two transactions in flight; neither may surface.
        new_rand();
        in_valid = 1;
        tick();
        new_rand();
        tick();
        in_valid = 0;
        rst_n = 0;
        #1;
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_product", 64'(o_product), 64'd0);
        chk("midrst_tag", 64'(o_tag), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1;
        for (int n = 0; n < 8; n++) tick();
        chk_lat = 1;
        single(32'd3, 32'd7, 0, 0, 16'd9, 64'd21);
        // Narrow operands at both pipeline-depth extremes.
        for (int s = 1; s <= 2; s++) begin
            set_cfg(s);
            single(32'h80, 32'h800, 1, 1, 16'd1, 64'h40000);
            single(32'hFF, 32'hFFF, 0, 0, 16'd0, 64'hFEF01);
            for (int j = 0; j < 64; j++) begin
                logic [31:0] bv;
                bv = $urandom & bmask;
                for (int a = 0; a < 256; a++) begin
                    in_a = 32'(a); in_b = bv; sa = j[0]; sb = 1'($urandom);
                    in_tag = 16'($urandom) & tmask;
                    in_valid = 1;
                    tick();
                end
            end
            in_valid = 0;
            drain();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
